// File: rtl/oflow_mem_buffer_initiator_fsm_if.sv
// Start/done handshake bundle between the frame initiator FSM and its environment.
// master = initiator side (drives requests), slave = scheduler/MEM side.
interface oflow_mem_buffer_initiator_fsm_if #(
    parameter int FRAME_W = 8,
    parameter int HIST_W  = 3
);
    logic               start_frame;
    logic [FRAME_W-1:0] frame_num;
    logic [HIST_W-1:0]  num_of_history_frames;
    logic               done_read;
    logic               done_write;
    logic               start_read;
    logic               start_write;
    logic [HIST_W-1:0]  history_idx;
    logic               busy;
    logic               frame_done;
    logic               timeout_err;
    logic               overrun_err;

    modport master (
        input  start_frame, frame_num, num_of_history_frames, done_read, done_write,
        output start_read, start_write, history_idx, busy, frame_done, timeout_err, overrun_err
    );

    modport slave (
        output start_frame, frame_num, num_of_history_frames, done_read, done_write,
        input  start_read, start_write, history_idx, busy, frame_done, timeout_err, overrun_err
    );
endinterface

// File: rtl/oflow_mem_buffer_initiator_fsm.sv
// Per-frame initiator: one start_read per valid history frame (newest first),
// then one start_write, each followed by a watchdog-guarded wait for its done.
module oflow_mem_buffer_initiator_fsm #(
    parameter int FRAME_W = 8,
    parameter int HIST_W  = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic reset_N,
    oflow_mem_buffer_initiator_fsm_if.master bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_WR_WAIT = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [2:0]        r_state;
    logic [HIST_W-1:0] r_hist_q;
    logic [HIST_W-1:0] r_history_idx;
    logic [WD_W-1:0]   r_wd;
    logic              r_start_read;
    logic              r_start_write;
    logic              r_busy;
    logic              r_frame_done;
    logic              r_timeout_err;
    logic              r_overrun_err;

    logic [HIST_W-1:0] w_hist_min;
    logic              w_wd_expired;
    logic              w_done_rd;
    logic              w_done_wr;

    // Frames older than frame 0 do not exist, so history depth is capped by frame_num.
    always_comb begin
        w_hist_min = bus.num_of_history_frames;
        if (bus.frame_num < FRAME_W'(bus.num_of_history_frames))
            w_hist_min = bus.frame_num[HIST_W-1:0];
    end

    // The request pulse is registered and shows up in the first WAIT cycle;
    // a done coincident with it belongs to nothing and is dropped.
    assign w_done_rd    = bus.done_read  && !r_start_read;
    assign w_done_wr    = bus.done_write && !r_start_write;
    assign w_wd_expired = (TIMEOUT != 0) && (r_wd == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_state       <= S_IDLE;
            r_hist_q      <= '0;
            r_history_idx <= '0;
            r_wd          <= '0;
            r_start_read  <= 1'b0;
            r_start_write <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_timeout_err <= 1'b0;
            r_overrun_err <= 1'b0;
        end else begin
            r_start_read  <= 1'b0;
            r_start_write <= 1'b0;
            r_frame_done  <= 1'b0;

            if (bus.start_frame && (r_state != S_IDLE))
                r_overrun_err <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (bus.start_frame) begin
                        r_busy        <= 1'b1;
                        r_timeout_err <= 1'b0;
                        r_overrun_err <= 1'b0;
                        r_hist_q      <= w_hist_min;
                        if (w_hist_min != '0) begin
                            r_history_idx <= HIST_W'(1);
                            r_state       <= S_RD_REQ;
                        end else begin
                            r_state <= S_WR_REQ;
                        end
                    end
                end
                S_RD_REQ: begin
                    r_start_read <= 1'b1;
                    r_wd         <= '0;
                    r_state      <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (w_done_rd) begin
                        if (r_history_idx < r_hist_q) begin
                            r_history_idx <= r_history_idx + HIST_W'(1);
                            r_state       <= S_RD_REQ;
                        end else begin
                            r_state <= S_WR_REQ;
                        end
                    end else if (w_wd_expired) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                S_WR_REQ: begin
                    r_start_write <= 1'b1;
                    r_wd          <= '0;
                    r_state       <= S_WR_WAIT;
                end
                S_WR_WAIT: begin
                    if (w_done_wr) begin
                        r_state <= S_DONE;
                    end else if (w_wd_expired) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                S_DONE: begin
                    r_frame_done  <= 1'b1;
                    r_busy        <= 1'b0;
                    r_history_idx <= '0;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.start_read  = r_start_read;
    assign bus.start_write = r_start_write;
    assign bus.history_idx = r_history_idx;
    assign bus.busy        = r_busy;
    assign bus.frame_done  = r_frame_done;
    assign bus.timeout_err = r_timeout_err;
    assign bus.overrun_err = r_overrun_err;

    a_req_exclusive: assert property (@(posedge clk) disable iff (!reset_N)
        !(r_start_read && r_start_write));
    a_no_req_idle: assert property (@(posedge clk) disable iff (!reset_N)
        (r_state == S_IDLE) |-> !(r_start_read || r_start_write) || r_frame_done == 1'b0);
endmodule

// File: tb/tb_oflow_mem_buffer_initiator_fsm.sv
// Randomised scoreboard bench for the MEM buffer initiator FSM with a responsive
// MEM model, timing checks on every pulse, and directed timeout/overrun/reset cases.
module tb_oflow_mem_buffer_initiator_fsm;
    localparam int TO = 16;
    localparam int EV_RD = 0;
    localparam int EV_WR = 1;
    localparam int EV_FD = 2;
    localparam int P_NONE = 0;
    localparam int P_RD = 1;
    localparam int P_WR = 2;

    typedef struct {
        int kind;
        int idx;
        int terr;
    } ev_t;

    logic clk = 1'b0;
    logic reset_N = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    bit   withhold = 1'b0;
    bit   slow = 1'b0;
    ev_t  exp_q[$];

    int trig_cyc = 0;
    int pend = 0;
    int pend_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    oflow_mem_buffer_initiator_fsm_if #(.FRAME_W(8), .HIST_W(3)) bus ();

    oflow_mem_buffer_initiator_fsm #(.FRAME_W(8), .HIST_W(3), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_N (reset_N),
        .bus     (bus)
    );

    function automatic void check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void sb_pop(int kind, int idx, int terr);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("sb_unexpected_event", kind, -1);
            return;
        end
        e = exp_q.pop_front();
        check("sb_kind", kind, e.kind);
        if (e.kind == EV_RD) check("sb_history_idx", idx, e.idx);
        if (e.kind == EV_FD) check("sb_timeout_err", terr, e.terr);
    endfunction

    // Monitor: pops the scoreboard on every output pulse and checks timing
    // against the last event that should have triggered it.
    always @(negedge clk) begin
        if (!reset_N) begin
            pend = P_NONE;
        end else begin
            if (bus.start_frame && !bus.busy) trig_cyc = cyc;
            if (pend == P_RD && bus.done_read && cyc > pend_cyc) begin
                trig_cyc = cyc;
                pend = P_NONE;
            end
            if (pend == P_WR && bus.done_write && cyc > pend_cyc) begin
                trig_cyc = cyc;
                pend = P_NONE;
            end
            if (bus.start_read || bus.start_write) begin
                check("req_exclusive", int'(bus.start_read && bus.start_write), 0);
                check("busy_on_req", int'(bus.busy), 1);
                sb_pop(bus.start_read ? EV_RD : EV_WR, int'(bus.history_idx), 0);
                check("req_latency", cyc, trig_cyc + 2);
                pend = bus.start_read ? P_RD : P_WR;
                pend_cyc = cyc;
            end
            if (bus.frame_done) begin
                sb_pop(EV_FD, 0, int'(bus.timeout_err));
                check("busy_at_frame_done", int'(bus.busy), 0);
                check("idx_at_frame_done", int'(bus.history_idx), 0);
                if (bus.timeout_err) check("timeout_latency", cyc, pend_cyc + TO + 1);
                else                 check("frame_done_latency", cyc, trig_cyc + 2);
                pend = P_NONE;
            end
        end
    end

    // MEM buffer model: answers each request after 1..6 cycles, sometimes
    // also raising the other done line, which the DUT must ignore.
    initial begin
        bit is_rd;
        int d;
        bus.done_read = 1'b0;
        bus.done_write = 1'b0;
        forever begin
            @(negedge clk);
            if (reset_N && (bus.start_read || bus.start_write)) begin
                is_rd = bus.start_read;
                if (is_rd && withhold) continue;
                d = slow ? 6 : int'($urandom_range(1, 6));
                repeat (d) @(posedge clk);
                #1;
                if (is_rd) begin
                    bus.done_read = 1'b1;
                    bus.done_write = 1'($urandom_range(0, 1));
                end else begin
                    bus.done_write = 1'b1;
                    bus.done_read = 1'($urandom_range(0, 1));
                end
                @(posedge clk);
                #1;
                bus.done_read = 1'b0;
                bus.done_write = 1'b0;
            end
        end
    end

    // Reference model: frame fn with depth n reads min(fn,n) frames newest
    // first, then writes, then completes; a withheld read times out instead.
    task automatic start(input int fn, input int n, input bit expect_to);
        int h;
        @(posedge clk);
        #1;
        h = (fn < n) ? fn : n;
        if (expect_to) begin
            exp_q.push_back('{EV_RD, 1, 0});
            exp_q.push_back('{EV_FD, 0, 1});
        end else begin
            for (int i = 1; i <= h; i++) exp_q.push_back('{EV_RD, i, 0});
            exp_q.push_back('{EV_WR, 0, 0});
            exp_q.push_back('{EV_FD, 0, 0});
        end
        bus.frame_num = 8'(fn);
        bus.num_of_history_frames = 3'(n);
        bus.start_frame = 1'b1;
        @(posedge clk);
        #1;
        bus.start_frame = 1'b0;
        bus.frame_num = 8'($urandom);
        bus.num_of_history_frames = 3'($urandom);
        @(negedge clk);
        check("busy_err_after_accept",
              int'({bus.busy, bus.timeout_err, bus.overrun_err}), 4);
    endtask

    task automatic wait_frame_done();
        int k;
        for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (bus.frame_done) break;
        end
        if (k == 400) check("frame_done_wait_expired", 0, 1);
    endtask

    task automatic wait_pulse(input bit want_rd, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (want_rd ? bus.start_read : bus.start_write) seen = 1'b1;
        end
        if (!seen) check("pulse_wait_expired", 0, 1);
    endtask

    initial begin
        bit seen;
        bus.start_frame = 1'b0;
        bus.frame_num = '0;
        bus.num_of_history_frames = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", int'({bus.start_read, bus.start_write, bus.history_idx,
              bus.busy, bus.frame_done, bus.timeout_err, bus.overrun_err}), 0);
        @(posedge clk);
        #1 reset_N = 1'b1;

        start(0, 3, 1'b0);   wait_frame_done();
        start(10, 3, 1'b0);  wait_frame_done();
        start(2, 5, 1'b0);   wait_frame_done();
        start(255, 7, 1'b0); wait_frame_done();
        start(0, 7, 1'b0);   wait_frame_done();

        withhold = 1'b1;
        start(5, 2, 1'b1);
        wait_frame_done();
        withhold = 1'b0;
        @(negedge clk);
        check("timeout_err_sticky", int'(bus.timeout_err), 1);

        start(10, 3, 1'b0);
        wait_pulse(1'b1, seen);
        @(posedge clk);
        #1 bus.start_frame = 1'b1;
        bus.frame_num = 8'd99;
        @(posedge clk);
        #1 bus.start_frame = 1'b0;
        @(negedge clk);
        check("overrun_set", int'(bus.overrun_err), 1);
        wait_frame_done();
        @(negedge clk);
        check("overrun_sticky", int'(bus.overrun_err), 1);
        start(4, 1, 1'b0);
        wait_frame_done();

        slow = 1'b1;
        start(0, 3, 1'b0);
        wait_pulse(1'b0, seen);
        @(posedge clk);
        #2 reset_N = 1'b0;
        #1;
        check("async_reset_outputs", int'({bus.start_read, bus.start_write, bus.history_idx,
              bus.busy, bus.frame_done, bus.timeout_err, bus.overrun_err}), 0);
        exp_q.delete();
        slow = 1'b0;
        @(posedge clk);
        #1 reset_N = 1'b1;
        @(posedge clk);
        #1 bus.done_write = 1'b1;
        @(posedge clk);
        #1 bus.done_write = 1'b0;
        repeat (12) @(negedge clk);
        check("post_reset_quiet", int'({bus.start_read, bus.start_write, bus.busy,
              bus.frame_done}), 0);

        for (int f = 0; f < 40; f++) begin
            start(int'($urandom_range(0, 255)), int'($urandom_range(0, 7)), 1'b0);
            wait_frame_done();
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
